// File: rtl/fl_distrib_sched_pkg.sv
// fl_distrib_sched_pkg
//   Shared types and helpers for the FrameLink distributor output scheduler.
//   - sched_state_t : ARB (choosing a port, SEL not valid) / HOLD (frame in flight)
//   - rr_next       : round-robin pointer increment with wrap at port_count-1 -> 0
package fl_distrib_sched_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } sched_state_t;

  localparam int DEF_OUTPUT_COUNT = 4;
  localparam int DEF_SEL_WIDTH    = 2;
  localparam int DEF_CNT_WIDTH    = 32;

  // Next round-robin start position after port p; port counts need not be powers of two.
  function automatic int rr_next(input int p, input int port_count);
    int nxt;
    if (p >= port_count - 1) begin
      nxt = 0;
    end else begin
      nxt = p + 1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fl_distrib_sched_rr_pick.sv
// fl_rr_pick
//   Combinational rotating priority encoder. Scans cand starting at ptr and
//   wrapping at OUTPUT_COUNT-1 -> 0; returns the first set position.
// Ports:
//   cand  in  OUTPUT_COUNT  candidate mask (1 = eligible)
//   ptr   in  SEL_WIDTH     first position to consider
//   idx   out SEL_WIDTH     winning position (0 when none found)
//   found out 1             at least one candidate was set
module fl_rr_pick
  import fl_distrib_sched_pkg::*;
#(
  parameter int OUTPUT_COUNT = DEF_OUTPUT_COUNT,
  parameter int SEL_WIDTH    = DEF_SEL_WIDTH
) (
  input  logic [OUTPUT_COUNT-1:0] cand,
  input  logic [SEL_WIDTH-1:0]    ptr,
  output logic [SEL_WIDTH-1:0]    idx,
  output logic                    found
);

  // Rotating scan: the modulo keeps positions inside 0..OUTPUT_COUNT-1 even
  // when OUTPUT_COUNT is not a power of two.
  always_comb begin
    int pos;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < OUTPUT_COUNT; k++) begin
      pos = (int'(ptr) + k) % OUTPUT_COUNT;
      if (!found && cand[pos]) begin
        found = 1'b1;
        idx   = SEL_WIDTH'(pos);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fl_distrib_sched.sv
// fl_distrib_sched
//   Frame-granular output scheduler for the FrameLink distributor (1 RX -> N TX).
//   Chooses a TX port per frame (round-robin over enabled and ready ports),
//   holds the choice from SOF to EOF by snooping the RX handshake, and inserts
//   one ARB bubble between frames.
// Ports:
//   CLK, RESET (async, active-low)
//   RX_SOF_N/RX_EOF_N/RX_SRC_RDY_N/RX_DST_RDY_N  snooped RX handshake (active-low)
//   TX_DST_RDY_N  per-port TX ready (active-low)
//   OUT_ENABLE    per-port eligibility mask
//   SEL/SEL_VLD   selected port and its validity
//   FRAMES_DONE   completed frame counter (wraps)
//   ERR           sticky protocol-error flag
module fl_distrib_sched
  import fl_distrib_sched_pkg::*;
#(
  parameter int OUTPUT_COUNT = DEF_OUTPUT_COUNT,
  parameter int SEL_WIDTH    = DEF_SEL_WIDTH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    RX_SOF_N,
  input  logic                    RX_EOF_N,
  input  logic                    RX_SRC_RDY_N,
  input  logic                    RX_DST_RDY_N,
  input  logic [OUTPUT_COUNT-1:0] TX_DST_RDY_N,
  input  logic [OUTPUT_COUNT-1:0] OUT_ENABLE,
  output logic [SEL_WIDTH-1:0]    SEL,
  output logic                    SEL_VLD,
  output logic [CNT_WIDTH-1:0]    FRAMES_DONE,
  output logic                    ERR
);

  sched_state_t         state_r, state_n;
  logic [SEL_WIDTH-1:0] sel_r, sel_n;
  logic                 sel_vld_r, sel_vld_n;
  logic [SEL_WIDTH-1:0] ptr_r, ptr_n;
  logic                 in_frame_r, in_frame_n;
  logic [CNT_WIDTH-1:0] frames_done_r, frames_done_n;
  logic                 err_r, err_n;

  logic                    xfer_s;
  logic                    sof_s;
  logic                    eof_s;
  logic [OUTPUT_COUNT-1:0] cand_s;
  logic [SEL_WIDTH-1:0]    pick_idx_s;
  logic                    pick_found_s;
  logic                    err_set_s;

  assign xfer_s = !RX_SRC_RDY_N && !RX_DST_RDY_N;
  assign sof_s  = xfer_s && !RX_SOF_N;
  assign eof_s  = xfer_s && !RX_EOF_N;
  assign cand_s = OUT_ENABLE & ~TX_DST_RDY_N;

  fl_rr_pick #(
    .OUTPUT_COUNT (OUTPUT_COUNT),
    .SEL_WIDTH    (SEL_WIDTH)
  ) u_pick (
    .cand  (cand_s),
    .ptr   (ptr_r),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Protocol errors: transfer while not granted, repeated SOF, data before SOF.
  assign err_set_s = (xfer_s && !sel_vld_r)
                   || (sof_s && in_frame_r)
                   || (xfer_s && RX_SOF_N && !in_frame_r && (state_r == HOLD));

  // Next-state and next-output computation for the ARB/HOLD scheduler.
  always_comb begin
    state_n       = state_r;
    sel_n         = sel_r;
    sel_vld_n     = sel_vld_r;
    ptr_n         = ptr_r;
    in_frame_n    = in_frame_r;
    frames_done_n = frames_done_r;
    err_n         = err_r | err_set_s;
    case (state_r)
      ARB: begin
        if (pick_found_s) begin
          sel_n     = pick_idx_s;
          sel_vld_n = 1'b1;
          state_n   = HOLD;
        end else begin
          sel_vld_n = 1'b0;
        end
      end
      HOLD: begin
        // EOF check comes first so a single-word SOF+EOF frame closes at once.
        if (eof_s) begin
          frames_done_n = frames_done_r + CNT_WIDTH'(1'b1);
          ptr_n         = SEL_WIDTH'(rr_next(int'(sel_r), OUTPUT_COUNT));
          in_frame_n    = 1'b0;
          sel_vld_n     = 1'b0;
          state_n       = ARB;
        end else if (sof_s) begin
          in_frame_n = 1'b1;
        end else begin
          in_frame_n = in_frame_r;
        end
      end
      default: begin
        sel_vld_n = 1'b0;
        state_n   = ARB;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r       <= ARB;
      sel_r         <= '0;
      sel_vld_r     <= 1'b0;
      ptr_r         <= '0;
      in_frame_r    <= 1'b0;
      frames_done_r <= '0;
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_n;
      sel_r         <= sel_n;
      sel_vld_r     <= sel_vld_n;
      ptr_r         <= ptr_n;
      in_frame_r    <= in_frame_n;
      frames_done_r <= frames_done_n;
      err_r         <= err_n;
    end
  end

  assign SEL         = sel_r;
  assign SEL_VLD     = sel_vld_r;
  assign FRAMES_DONE = frames_done_r;
  assign ERR         = err_r;

endmodule
